// File: rtl/rule110_run_ctrl_if.sv
// rtl/rule110_run_ctrl_if.sv - requester-side run handshake for rule110_run_ctrl
// master = requester, slave = run controller.
interface rule110_run_ctrl_if #(
  parameter int N     = 512,
  parameter int GEN_W = 16
);
  localparam int PW = $clog2(N + 1);

  logic             start;
  logic [N-1:0]     seed;
  logic [GEN_W-1:0] gen_limit;
  logic             abort;
  logic             busy;
  logic             done;
  logic [GEN_W-1:0] gens;
  logic [1:0]       reason;
  logic [PW-1:0]    pop_cnt;

  modport master (
    output start, seed, gen_limit, abort,
    input  busy, done, gens, reason, pop_cnt
  );

  modport slave (
    input  start, seed, gen_limit, abort,
    output busy, done, gens, reason, pop_cnt
  );
endinterface

// File: rtl/rule110_run_ctrl.sv
// rtl/rule110_run_ctrl.sv - run controller for an N-cell Rule-110 automaton
// Optional final-pattern popcount is enabled by defining RULE110_POPCNT_EN.
module rule110_run_ctrl #(
  parameter int N     = 512,
  parameter int GEN_W = 16
) (
  input  logic           clk,
  input  logic           areset,
  rule110_run_ctrl_if.slave req,
  output logic           ca_load,
  output logic [N-1:0]   ca_data,
  input  logic [N-1:0]   ca_q
);
  localparam int PW = $clog2(N + 1);

  localparam logic [1:0] R_LIMIT  = 2'd0;
  localparam logic [1:0] R_EMPTY  = 2'd1;
  localparam logic [1:0] R_STABLE = 2'd2;
  localparam logic [1:0] R_ABORT  = 2'd3;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t           state, state_nx;
  logic [N-1:0]     seed_r, prev_q;
  logic [GEN_W-1:0] lim_r, gen_cnt, gens_r;
  logic [1:0]       reason_r, reason_nx;
  logic             done_r;
  logic             is_empty, is_stable, at_limit, stop_now;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    is_empty  = (ca_q == '0);
    is_stable = (gen_cnt != '0) && (ca_q == prev_q);
    at_limit  = (gen_cnt == lim_r);
    stop_now  = (state == RUN) && (req.abort || is_empty || is_stable || at_limit);

    // Priority ABORT > EMPTY > STABLE > LIMIT; an all-zero pattern is never STABLE.
    if (req.abort)     reason_nx = R_ABORT;
    else if (is_empty) reason_nx = R_EMPTY;
    else if (is_stable) reason_nx = R_STABLE;
    else               reason_nx = R_LIMIT;

    case (state)
      IDLE:    if (req.start) state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (stop_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    ca_load = (state != RUN) || stop_now;
    ca_data = (state == LOAD) ? seed_r : ca_q;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      seed_r   <= '0;
      lim_r    <= '0;
      gen_cnt  <= '0;
      prev_q   <= '0;
      gens_r   <= '0;
      reason_r <= R_LIMIT;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (req.start) begin
            seed_r  <= req.seed;
            lim_r   <= req.gen_limit;
            gen_cnt <= '0;
          end
        end
        RUN: begin
          if (stop_now) begin
            gens_r   <= gen_cnt;
            reason_r <= reason_nx;
            done_r   <= 1'b1;
          end else begin
            gen_cnt <= gen_cnt + GEN_W'(1);
            prev_q  <= ca_q;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RULE110_POPCNT_EN
  logic [PW-1:0] pop_nx, pop_r;

  always_comb begin
    pop_nx = '0;
    for (int i = 0; i < N; i++) pop_nx = pop_nx + PW'(ca_q[i]);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset)                         pop_r <= '0;
    else if (state == RUN && stop_now)  pop_r <= pop_nx;
  end

  assign req.pop_cnt = pop_r;
`else
  assign req.pop_cnt = '0;
`endif

  assign req.busy   = (state != IDLE);
  assign req.done   = done_r;
  assign req.gens   = gens_r;
  assign req.reason = reason_r;
endmodule

// File: doc/rule110_run_ctrl.md
Name: rule110_run_ctrl

Overview:
- Run controller for the N-cell Rule-110 automaton (clk/load/data/q datapath).
- Accepts a seed pattern and a generation limit from a requester over a start/busy/done handshake.
- Loads the seed into the automaton, lets it step once per clock, and freezes it on one of four stop conditions: limit reached, all-zero, fixed point, or abort.
- Reports the stop reason and the number of generations executed.

Parameters:
- N, 512, cell count; width of seed and automaton buses.
- GEN_W, 16, width of generation limit and counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- areset  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- seed  in  N  initial pattern; captured when start is accepted.
- gen_limit  in  GEN_W  number of generations to run; captured with seed.
- abort  in  1  stop request; effective in RUN only.
- busy  out  1  high from the cycle after start acceptance through the stop cycle.
- done  out  1  one-cycle pulse, the cycle after the stop cycle.
- gens  out  GEN_W  generations executed in the last run; valid from done, held until next done.
- reason  out  2  0=LIMIT, 1=EMPTY, 2=STABLE, 3=ABORT; valid/held like gens.
- pop_cnt  out  $clog2(N+1)  population count of the final pattern (optional feature).
- ca_load  out  1  to automaton load.
- ca_data  out  N  to automaton data.
- ca_q  in  N  from automaton q.

Behaviour:
- Reset (async, areset=1):
  - state=IDLE; busy=0, done=0, gens=0, reason=0, pop_cnt=0.
  - seed_r, lim_r, gen_cnt and prev_q cleared.
  - The automaton is held: ca_load=1, ca_data=ca_q.
  - Reset mid-RUN freezes the pattern at its current generation and produces no done pulse.
- States: IDLE, LOAD, RUN.
- Hold rule: ca_load = (state!=RUN) | stop_now. ca_data = seed_r when state==LOAD, otherwise ca_q. Outside LOAD and RUN, or once stopped, the automaton therefore never changes.
- IDLE: when start=1, capture seed_r<=seed, lim_r<=gen_limit and gen_cnt<=0, then go to LOAD. A start in the same cycle as a done pulse is accepted.
- LOAD: lasts one cycle. The edge writes the seed into the automaton. Next state RUN; busy=1.
- RUN:
  - Each cycle, ca_q holds generation gen_cnt.
  - stop_now is combinational: abort | (ca_q==0) | (gen_cnt!=0 & ca_q==prev_q) | (gen_cnt==lim_r).
  - If stop_now=0: the edge advances the automaton, gen_cnt<=gen_cnt+1, prev_q<=ca_q.
  - If stop_now=1: the automaton holds, gens<=gen_cnt, reason<=(priority-encoded), done<=1 for the next cycle, and state goes to IDLE.
- Stop-reason priority: ABORT > EMPTY > STABLE > LIMIT. An all-zero pattern reports EMPTY, never STABLE.
- gen_limit=0 stops on the first RUN cycle with gens=0, unless EMPTY or ABORT applies.
- Latency: from the start cycle, the first RUN cycle is start+2. done arrives at start+3+gens.
- gen_cnt cannot wrap, because the stop on equality with lim_r precedes overflow.
- start while busy=1 is ignored. abort outside RUN is ignored.

Optional Feature:
- Macro RULE110_POPCNT_EN.
- Defined: on the stop cycle, pop_cnt <= number of 1 bits in ca_q, updated with gens/reason and held until the next done.
- Undefined: pop_cnt is tied to 0 and no popcount logic is generated.

Test Plan:
1. Single seed, limit reached: N=512, seed bit 256 only, gen_limit=20, start pulsed. Required response:
   - busy high for 22 cycles; done at start+23.
   - gens=20, reason=0.
   - ca_q has no bit set below 256 or above 276, with bit 276=1.
   - ca_q is unchanged for the next 10 cycles.
2. Zero seed: seed=0, gen_limit=50. Required response: done at start+3, gens=0, reason=1 (EMPTY).
3. Fixed point: seed bit 511 only, gen_limit=50. Required response: done at start+4, gens=1, reason=2 (STABLE); ca_q equals bit 511 only.
4. Abort: seed bit 256, gen_limit=100, abort=1 on the 6th RUN cycle. Required response:
   - gens=5, reason=3 (ABORT).
   - ca_q frozen at generation 5: bits 256..261 region only.
   - A start pulse during RUN is ignored: no second done.
5. Reset mid-run: areset pulsed during RUN at gen 7. Required response:
   - busy=0, gens=0, reason=0 immediately, and no done pulse.
   - ca_q stays at generation 7.
   - A new start afterwards completes normally.
6. Popcount (RULE110_POPCNT_EN defined): seed bit 256, gen_limit=1. Required response: gens=1, pop_cnt=2. With the macro undefined, pop_cnt=0.
